mem_bist_march: RTL and testbench

MEM_BIST_MARCH -- requirements
Module: mem_bist_march

---
 rtl/mem_bist_pkg.sv | 38 +++
 rtl/mem_bist_addr_gen.sv | 31 +++
 rtl/mem_bist_march.sv | 161 ++++++++++++++++
 tb/tb_mem_bist_march.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the March C- memory BIST engine.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } bist_state_e;

  typedef enum logic [2:0] {
    EL_W0_UP   = 3'd0,
    EL_R0W1_UP = 3'd1,
    EL_R1W0_UP = 3'd2,
    EL_R0W1_DN = 3'd3,
    EL_R1W0_DN = 3'd4,
    EL_R0_UP   = 3'd5
  } march_elem_e;

  localparam int MARCH_OPS_PER_WORD = 10;

  function automatic logic elem_down(input march_elem_e e);
    return (e == EL_R0W1_DN) || (e == EL_R1W0_DN);
  endfunction

  function automatic logic elem_two_op(input march_elem_e e);
    return (e != EL_W0_UP) && (e != EL_R0_UP);
  endfunction

  // Read expects ~bg in the r1 elements; write stores ~bg in the w1 elements.
  function automatic logic elem_rd_inv(input march_elem_e e);
    return (e == EL_R1W0_UP) || (e == EL_R1W0_DN);
  endfunction

  function automatic logic elem_wr_inv(input march_elem_e e);
    return (e == EL_R0W1_UP) || (e == EL_R0W1_DN);
  endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter; last flags the final address of the sweep.
module mem_bist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_dn,
  input  logic              step,
  input  logic              dn,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load)      addr_d = load_dn ? '1 : '0;
    else if (step) addr_d = dn ? addr_q - 1'b1 : addr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign last = dn ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mem_bist_march.sv
// March C- BIST engine: one memory op per cycle, read compares pipelined one
// cycle behind issue, first-failure capture.
module mem_bist_march
  import mem_bist_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bg,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  bist_state_e       state_q, state_d;
  march_elem_e       elem_q, elem_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] bg_q, bg_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic              done_q, done_d;

  logic              run, two_op, is_rd, is_wr, word_done;
  logic              ag_load, ag_load_dn, ag_step, ag_last;
  logic [ADDR_W-1:0] addr;
  march_elem_e       elem_nxt;

  mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ag_load),
    .load_dn (ag_load_dn),
    .step    (ag_step),
    .dn      (elem_down(elem_q)),
    .addr    (addr),
    .last    (ag_last)
  );

  always_comb begin
    run       = (state_q == ST_RUN);
    two_op    = elem_two_op(elem_q);
    is_rd     = run && ((elem_q == EL_R0_UP) || (two_op && !phase_q));
    is_wr     = run && !is_rd;
    word_done = !two_op || phase_q;
    elem_nxt  = march_elem_e'(elem_q + 3'd1);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    bg_d        = bg_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    done_d      = 1'b0;
    ag_load     = 1'b0;
    ag_load_dn  = 1'b0;
    ag_step     = 1'b0;

    cmp_vld_d  = is_rd;
    exp_d      = elem_rd_inv(elem_q) ? ~bg_q : bg_q;
    cmp_addr_d = addr;

    if (cmp_vld_q && (mem_dout != exp_q) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_data_d = mem_dout;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          elem_d      = EL_W0_UP;
          phase_d     = 1'b0;
          bg_d        = bg;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          ag_load     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!word_done) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!ag_last) begin
            ag_step = 1'b1;
          end else if (elem_q == EL_R0_UP) begin
            state_d = ST_FINISH;
          end else begin
            // Reload instead of wrapping so each sweep starts cleanly.
            elem_d     = elem_nxt;
            ag_load    = 1'b1;
            ag_load_dn = elem_down(elem_nxt);
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= EL_W0_UP;
      phase_q     <= 1'b0;
      bg_q        <= '0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      bg_q        <= bg_d;
      cmp_vld_q   <= cmp_vld_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd    = is_rd;
  assign mem_wr    = is_wr;
  assign mem_addr  = run ? addr : '0;
  assign mem_din   = is_wr ? (elem_wr_inv(elem_q) ? ~bg_q : bg_q) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_bist_march.sv
// Scoreboard bench: expected op stream and done results are queued at launch,
// negedge monitors pop and compare as the two DUTs (4x16, 8x8) present them.
module tb_mem_bist_march;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
    int         rel;
  } op_t;

  typedef struct {
    int         rel;
    logic       fail;
    logic [7:0] fa;
    logic [7:0] fd;
  } dn_t;

  logic clk, rst_n;
  int   cyc = 0;
  int   sc[3];
  int   n_chk = 0, n_pass = 0;
  int   fmode = 0;

  op_t q1[$], q2[$];
  dn_t qd1[$], qd2[$];

  logic       start1, rd1, wr1, busy1, done1, fail1;
  logic [3:0] bg1, a1, din1, dout1, fa1, fd1;
  logic       start2, rd2, wr2, busy2, done2, fail2;
  logic [7:0] bg2, din2, dout2, fd2;
  logic [2:0] a2, fa2;
  logic [3:0] m1 [16];
  logic [7:0] m2 [8];

  mem_bist_march dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bg(bg1),
    .mem_rd(rd1), .mem_wr(wr1), .mem_addr(a1), .mem_din(din1), .mem_dout(dout1),
    .busy(busy1), .done(done1), .fail(fail1), .fail_addr(fa1), .fail_data(fd1)
  );

  mem_bist_march #(.DATA_W(8), .ADDR_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bg(bg2),
    .mem_rd(rd2), .mem_wr(wr2), .mem_addr(a2), .mem_din(din2), .mem_dout(dout2),
    .busy(busy2), .done(done2), .fail(fail2), .fail_addr(fa2), .fail_data(fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: fmode 1 = bit 2 stuck-at-1 at addr 5, fmode 2 = write to 3 aliases 11.
  initial begin dout1 = '0; dout2 = '0; end
  always @(posedge clk) begin
    if (wr1) begin
      m1[a1] <= din1;
      if (fmode == 2 && a1 == 4'd3) m1[11] <= din1;
    end
    if (rd1) dout1 <= (fmode == 1 && a1 == 4'd5) ? (m1[a1] | 4'h4) : m1[a1];
    if (wr2) m2[a2] <= din2;
    if (rd2) dout2 <= m2[a2];
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic push_op(input int sel, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d, input int k);
    op_t o;
    o.rd = rd; o.wr = wr; o.addr = a; o.din = d; o.rel = k;
    if (sel == 1) q1.push_back(o); else q2.push_back(o);
  endtask

  // March C-: up w0; up r0,w1; up r1,w0; down r0,w1; down r1,w0; up r0.
  task automatic gen_ops(input int sel, input logic [7:0] bgv);
    int n, k;
    logic [7:0] m, a, b0, b1;
    n = (sel == 1) ? 16 : 8;
    m = (sel == 1) ? 8'h0F : 8'hFF;
    b0 = bgv & m;
    b1 = ~bgv & m;
    k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        a = (e == 3 || e == 4) ? 8'(n - 1 - i) : 8'(i);
        if (e == 0) begin
          push_op(sel, 1'b0, 1'b1, a, b0, k); k++;
        end else begin
          push_op(sel, 1'b1, 1'b0, a, 8'h00, k); k++;
          if (e != 5) begin
            push_op(sel, 1'b0, 1'b1, a, (e == 1 || e == 3) ? b1 : b0, k); k++;
          end
        end
      end
    end
  endtask

  task automatic mon(input int sel, input logic rd, input logic wr, input logic [7:0] a,
                     input logic [7:0] d, input logic dn, input logic bsy, input logic fl,
                     input logic [7:0] fa, input logic [7:0] fd);
    int rel, qs;
    op_t o;
    dn_t x;
    rel = cyc - sc[sel];
    if (rd || wr) begin
      qs = (sel == 1) ? q1.size() : q2.size();
      if (qs == 0) begin
        n_chk++;
        $display("FAIL op%0d_unexpected rd=%0b wr=%0b addr=%0h rel=%0d", sel, rd, wr, a, rel);
      end else begin
        if (sel == 1) o = q1.pop_front(); else o = q2.pop_front();
        check($sformatf("op%0d_k%0d{rel,rd,wr,addr,din}", sel, o.rel),
              {32'(rel), rd, wr, a, d}, {32'(o.rel), o.rd, o.wr, o.addr, o.din});
      end
    end
    if (dn) begin
      qs = (sel == 1) ? qd1.size() : qd2.size();
      if (qs == 0) begin
        n_chk++;
        $display("FAIL done%0d_unexpected rel=%0d", sel, rel);
      end else begin
        if (sel == 1) x = qd1.pop_front(); else x = qd2.pop_front();
        check($sformatf("done%0d{rel,busy,fail,fa,fd}", sel),
              {32'(rel), bsy, fl, fa, fd}, {32'(x.rel), 1'b0, x.fail, x.fa, x.fd});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1, rd1, wr1, {4'h0, a1}, {4'h0, din1}, done1, busy1, fail1, {4'h0, fa1}, {4'h0, fd1});
    mon(2, rd2, wr2, {5'h0, a2}, din2, done2, busy2, fail2, {5'h0, fa2}, fd2);
  end

  task automatic launch(input int sel, input logic [7:0] bgv, input logic ef,
                        input logic [7:0] efa, input logic [7:0] efd);
    dn_t x;
    gen_ops(sel, bgv);
    x.rel = (sel == 1) ? 161 : 81; x.fail = ef; x.fa = efa; x.fd = efd;
    if (sel == 1) qd1.push_back(x); else qd2.push_back(x);
    @(negedge clk);
    sc[sel] = cyc + 1;
    if (sel == 1) begin start1 = 1'b1; bg1 = bgv[3:0]; end
    else begin start2 = 1'b1; bg2 = bgv; end
    @(posedge clk);
    #1 start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_rel(input int sel, input int r);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cyc - sc[sel] == r) return;
    end
    check("wait_rel_timeout", 64'd1, 64'd0);
  endtask

  task automatic finish(input int sel, input logic ef, input logic [7:0] efa, input logic [7:0] efd);
    int qs;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      qs = (sel == 1) ? qd1.size() : qd2.size();
      if (qs == 0) break;
    end
    #1;
    check($sformatf("done%0d_seen_pending", sel), 64'(qs), 64'd0);
    qs = (sel == 1) ? q1.size() : q2.size();
    check($sformatf("ops%0d_all_issued_pending", sel), 64'(qs), 64'd0);
    repeat (3) @(negedge clk);
    if (sel == 1)
      check("hold1{busy,done,fail,fa,fd}", {busy1, done1, fail1, fa1, fd1}, {2'b00, ef, efa[3:0], efd[3:0]});
    else
      check("hold2{busy,done,fail,fa,fd}", {busy2, done2, fail2, fa2, fd2}, {2'b00, ef, efa[2:0], efd});
  endtask

  task automatic chk_reset(input string nm);
    check({nm, "_dut1"}, {busy1, done1, fail1, rd1, wr1, a1, din1, fa1, fd1}, 64'd0);
    check({nm, "_dut2"}, {busy2, done2, fail2, rd2, wr2, a2, din2, fa2, fd2}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; bg1 = '0; bg2 = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free 4x16, bg 0: done at 161, no fail.
    fmode = 0;
    launch(1, 8'h00, 1'b0, 8'h0, 8'h0);
    finish(1, 1'b0, 8'h0, 8'h0);

    // Stuck-at-1 bit 2 at address 5: first r0 miscompare sees 4.
    fmode = 1;
    launch(1, 8'h00, 1'b1, 8'h5, 8'h4);
    finish(1, 1'b1, 8'h5, 8'h4);

    // Decoder alias 3->11, bg A: E1 writes 5 into 11 before reading it.
    fmode = 2;
    launch(1, 8'h0A, 1'b1, 8'hB, 8'h5);
    finish(1, 1'b1, 8'hB, 8'h5);

    // Restarts at rel 20 and 100 with a different bg must be ignored; fail cleared.
    fmode = 0;
    launch(1, 8'h00, 1'b0, 8'h0, 8'h0);
    wait_rel(1, 20);
    start1 = 1'b1; bg1 = 4'hF;
    @(posedge clk); #1 start1 = 1'b0;
    wait_rel(1, 100);
    start1 = 1'b1; bg1 = 4'h3;
    @(posedge clk); #1 start1 = 1'b0;
    finish(1, 1'b0, 8'h0, 8'h0);

    // Mid-run reset at rel 50: immediate reset values, no done, then IDLE.
    fmode = 1;
    launch(1, 8'h05, 1'b1, 8'h5, 8'h4);
    wait_rel(1, 50);
    #1;
    q1.delete(); qd1.delete();
    rst_n = 1'b0;
    #1 chk_reset("async_reset_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release{busy,done,rd,wr}", {busy1, done1, rd1, wr1}, 64'd0);
    repeat (170) @(negedge clk);
    check("no_done_after_abort{busy,done}", {busy1, done1}, 64'd0);

    // Fresh run after abort, bg 5 with stuck bit: expect 5 read, 5|4 = 5? no: r0 expects 5, bit2 already 1 -> passes; r1 expects A -> sees E.
    fmode = 1;
    launch(1, 8'h05, 1'b1, 8'h5, 8'hE);
    finish(1, 1'b1, 8'h5, 8'hE);

    // 8-bit x 8-word instance: done at 81, down sweeps 7..0.
    fmode = 0;
    launch(2, 8'h3C, 1'b0, 8'h0, 8'h00);
    finish(2, 1'b0, 8'h0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
